// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: grants the ALU
// path (A) or the load path (M) each cycle and registers the winning write.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        m_valid,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    output logic        m_ready,
    output logic        write,
    output logic [4:0]  reg_write,
    output logic [31:0] wdata,
    output logic        a_starved
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        write_q, write_d;
    logic [4:0]  reg_write_q, reg_write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        a_grant, m_grant;

    assign a_starved = (wait_cnt_q == LIMIT);

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        a_grant = rst_n && !hold && a_valid && (a_starved || !m_valid);
        m_grant = rst_n && !hold && m_valid && !a_grant;
    end

    assign a_ready = a_grant;
    assign m_ready = m_grant;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        write_d     = 1'b0;
        reg_write_d = reg_write_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;

        if (a_grant) begin
            write_d     = (a_addr != 5'd0);
            reg_write_d = a_addr;
            wdata_d     = a_data;
        end else if (m_grant) begin
            write_d     = (m_addr != 5'd0);
            reg_write_d = m_addr;
            wdata_d     = m_data;
        end

        // The counter freezes under hold because A is merely blocked, not losing.
        if (!a_valid || a_grant) begin
            wait_cnt_d = 4'd0;
        end else if (!hold && (wait_cnt_q < LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            reg_write_q <= 5'd0;
            wdata_q     <= 32'd0;
            wait_cnt_q  <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            write_q     <= write_d;
            reg_write_q <= reg_write_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign write     = write_q;
    assign reg_write = reg_write_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a cycle-level model
// of the arbitration, starvation and output-stage rules.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        a_valid, m_valid;
    logic [4:0]  a_addr, m_addr;
    logic [31:0] a_data, m_data;
    logic        a_ready, m_ready;
    logic        write;
    logic [4:0]  reg_write;
    logic [31:0] wdata;
    logic        a_starved;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_wait;
    logic        exp_write;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_a_rdy, exp_m_rdy, exp_starved_pre;
    logic        obs_a_rdy, obs_m_rdy, obs_starved_pre;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .write     (write),
        .reg_write (reg_write),
        .wdata     (wdata),
        .a_starved (a_starved)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_wait    = 0;
        exp_write = 1'b0;
        exp_addr  = 5'd0;
        exp_data  = 32'd0;
    endtask

    // One clock cycle: drive at negedge, sample readys, advance model over the edge.
    task automatic step(input logic hv, input logic av, input logic [4:0] aa,
                        input logic [31:0] ad, input logic mv,
                        input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        hold = hv; a_valid = av; a_addr = aa; a_data = ad;
        m_valid = mv; m_addr = ma; m_data = md;
        #1;
        exp_starved_pre = (m_wait == LIMIT);
        exp_a_rdy = !hv && av && (exp_starved_pre || !mv);
        exp_m_rdy = !hv && mv && !exp_a_rdy;
        obs_a_rdy = a_ready;
        obs_m_rdy = m_ready;
        obs_starved_pre = a_starved;
        @(posedge clk);
        if (exp_a_rdy) begin
            exp_write = (aa != 5'd0); exp_addr = aa; exp_data = ad;
        end else if (exp_m_rdy) begin
            exp_write = (ma != 5'd0); exp_addr = ma; exp_data = md;
        end else begin
            exp_write = 1'b0;
        end
        if (!av || exp_a_rdy) m_wait = 0;
        else if (!hv && m_wait < LIMIT) m_wait++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1111_1111;
        m_valid = 1'b1; m_addr = 5'd6; m_data = 32'h2222_2222;
        model_reset();
        #12;
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", write); end
        n_checks++; if (reg_write !== 5'd0) begin n_fail++; $display("FAIL reset_reg_write: got %0d want 0", reg_write); end
        n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        n_checks++; if (a_ready !== 1'b0 || m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got a=%b m=%b want 0 0", a_ready, m_ready); end
        n_checks++; if (a_starved !== 1'b0) begin n_fail++; $display("FAIL reset_starved: got %b want 0", a_starved); end
        @(negedge clk); rst_n = 1'b1;
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222);
        n_checks++; if (obs_m_rdy !== 1'b1 || obs_a_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_first_grant: got a=%b m=%b want a=0 m=1", obs_a_rdy, obs_m_rdy); end
        n_checks++; if (write !== 1'b1 || reg_write !== 5'd6 || wdata !== 32'h2222_2222) begin n_fail++; $display("FAIL reset_first_write: got %b %0d %h want 1 6 22222222", write, reg_write, wdata); end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        n_checks++; if (obs_a_rdy !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b want 1", obs_a_rdy); end
        n_checks++; if (write !== 1'b1 || reg_write !== 5'd8 || wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL single_write: got %b %0d %h want 1 8 00001234", write, reg_write, wdata); end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (write !== 1'b0 || reg_write !== 5'd8 || wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL single_idle: got %b %0d %h want 0 8 00001234", write, reg_write, wdata); end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i <= 3), 5'd5, 32'hAAAA_AAAA, 1'b1, 5'(10 + i), 32'hC000_0000 + 32'(i));
            n_checks++; if (obs_a_rdy !== (i == 3) || obs_m_rdy !== (i != 3)) begin n_fail++; $display("FAIL starve_grant[%0d]: got a=%b m=%b want a=%b m=%b", i, obs_a_rdy, obs_m_rdy, (i == 3), (i != 3)); end
            n_checks++; if (obs_starved_pre !== (i == 3)) begin n_fail++; $display("FAIL starve_flag[%0d]: got %b want %b", i, obs_starved_pre, (i == 3)); end
            n_checks++; if (write !== exp_write || reg_write !== exp_addr || wdata !== exp_data) begin n_fail++; $display("FAIL starve_out[%0d]: got %b %0d %h want %b %0d %h", i, write, reg_write, wdata, exp_write, exp_addr, exp_data); end
            if (i == 3) begin
                n_checks++; if (dut.wait_cnt_q !== 4'd0) begin n_fail++; $display("FAIL starve_clear: got %0d want 0", dut.wait_cnt_q); end
            end
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reg_zero();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        n_checks++; if (obs_m_rdy !== 1'b1) begin n_fail++; $display("FAIL zero_m_ready: got %b want 1", obs_m_rdy); end
        n_checks++; if (write !== 1'b0 || reg_write !== 5'd0 || wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL zero_write: got %b %0d %h want 0 0 ffffffff", write, reg_write, wdata); end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 5'd5, 32'hAAAA_AAAA, 1'b1, 5'(20 + i), 32'hD000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 5'd5, 32'hAAAA_AAAA, 1'b1, 5'd22, 32'hD000_0002);
            n_checks++; if (obs_a_rdy !== 1'b0 || obs_m_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got a=%b m=%b want 0 0", i, obs_a_rdy, obs_m_rdy); end
            n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL hold_write[%0d]: got %b want 0", i, write); end
            n_checks++; if (dut.wait_cnt_q !== 4'd2) begin n_fail++; $display("FAIL hold_wait[%0d]: got %0d want 2", i, dut.wait_cnt_q); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 5'd5, 32'hAAAA_AAAA, 1'b1, 5'd22, 32'hD000_0002);
            n_checks++; if (obs_a_rdy !== (i == 1) || obs_m_rdy !== (i == 0)) begin n_fail++; $display("FAIL hold_resume[%0d]: got a=%b m=%b want a=%b m=%b", i, obs_a_rdy, obs_m_rdy, (i == 1), (i == 0)); end
            n_checks++; if (write !== exp_write || reg_write !== exp_addr || wdata !== exp_data) begin n_fail++; $display("FAIL hold_out[%0d]: got %b %0d %h want %b %0d %h", i, write, reg_write, wdata, exp_write, exp_addr, exp_data); end
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 5'd7, 32'h7777_0000, 1'b1, 5'(1 + i), 32'h5555_0000 + 32'(i));
        n_checks++; if (write !== 1'b1) begin n_fail++; $display("FAIL mid_pre_write: got %b want 1", write); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL mid_write_drop: got %b want 0", write); end
        n_checks++; if (a_ready !== 1'b0 || m_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got a=%b m=%b want 0 0", a_ready, m_ready); end
        n_checks++; if (dut.wait_cnt_q !== 4'd0) begin n_fail++; $display("FAIL mid_wait: got %0d want 0", dut.wait_cnt_q); end
        a_valid = 1'b0; m_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 5'd7, 32'h7777_0000, 1'b1, 5'(1 + i), 32'h5555_0000 + 32'(i));
            n_checks++; if (obs_a_rdy !== (i == 3) || obs_m_rdy !== (i != 3)) begin n_fail++; $display("FAIL mid_regrant[%0d]: got a=%b m=%b want a=%b m=%b", i, obs_a_rdy, obs_m_rdy, (i == 3), (i != 3)); end
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_random();
        logic        a_pend = 1'b0, m_pend = 1'b0, hv;
        logic [4:0]  aa = 5'd0, ma = 5'd0;
        logic [31:0] ad = 32'd0, md = 32'd0;
        for (int i = 0; i < 200; i++) begin
            if (!a_pend) begin a_pend = $urandom_range(0, 2) != 0; aa = 5'($urandom); ad = $urandom; end
            if (!m_pend) begin m_pend = $urandom_range(0, 2) != 0; ma = 5'($urandom); md = $urandom; end
            hv = ($urandom_range(0, 7) == 0);
            step(hv, a_pend, aa, ad, m_pend, ma, md);
            n_checks++; if (obs_a_rdy !== exp_a_rdy || obs_m_rdy !== exp_m_rdy) begin n_fail++; $display("FAIL rand_grant[%0d]: got a=%b m=%b want a=%b m=%b", i, obs_a_rdy, obs_m_rdy, exp_a_rdy, exp_m_rdy); end
            n_checks++; if (obs_starved_pre !== exp_starved_pre) begin n_fail++; $display("FAIL rand_starved[%0d]: got %b want %b", i, obs_starved_pre, exp_starved_pre); end
            n_checks++; if (write !== exp_write || reg_write !== exp_addr || wdata !== exp_data) begin n_fail++; $display("FAIL rand_out[%0d]: got %b %0d %h want %b %0d %h", i, write, reg_write, wdata, exp_write, exp_addr, exp_data); end
            if (exp_a_rdy) a_pend = 1'b0;
            if (exp_m_rdy) m_pend = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_starvation();
        test_reg_zero();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
